laser_tx_scheduler: RTL and testbench

- Sequences the laser transmit path.
- Accepts one finished 9-word packet at a time from the packet generator and streams it word-by-word to the laser bit serializer over a valid/ready handshake.
- Enforces an inter-packet gap, then reports completion to the main TCP state machine as a packetsent pulse.
- Owns the go-back-n retransmission timer and pulses timeout when no ACK progress arrives in time.

---
 rtl/lasernet_pkg.sv | 22 ++
 rtl/retx_timer.sv | 44 ++++
 rtl/laser_tx_scheduler.sv | 171 +++++++++++++++++
 tb/tb_laser_tx_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lasernet_pkg.sv
// Shared definitions for the laser transmit path.
// Holds the scheduler state encoding, the serializer word width and the
// default timing parameters for a 65 MHz system clock.
package lasernet_pkg;

    // Serializer word width
    localparam int unsigned WORD_W = 32;

    // Defaults at 65 MHz
    localparam int unsigned DEF_WORDS          = 9;
    localparam int unsigned DEF_GAP_CYCLES     = 650;        // 10 us
    localparam int unsigned DEF_TIMEOUT_CYCLES = 65_000_000; // 1 s
    localparam int unsigned DEF_TIMER_W        = 27;

    // Transmit scheduler states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/retx_timer.sv
// Go-back-n retransmission timer.
// Counts enabled cycles since the last clear and emits a one-cycle timeout
// pulse when TIMEOUT_CYCLES elapse with no clear, then restarts the period.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   enable       - unacknowledged data outstanding; counter held at 0 when low
//   clear        - ACK progress or packet sent; restarts the period
//   timeout      - registered one-cycle expiry pulse
module retx_timer
    import lasernet_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned TIMER_W        = DEF_TIMER_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic timeout
);

    logic [TIMER_W-1:0] count;
    logic               at_limit;

    assign at_limit = (count == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Clear has priority over expiry, so a coincident clear suppresses the pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            timeout <= 1'b0;
        end else if (!enable || clear) begin
            count   <= '0;
            timeout <= 1'b0;
        end else if (at_limit) begin
            count   <= '0;
            timeout <= 1'b1;
        end else begin
            count   <= count + TIMER_W'(1);
            timeout <= 1'b0;
        end
    end

endmodule

// File: rtl/laser_tx_scheduler.sv
// Laser transmit scheduler.
// Captures one WORDS-word packet from the generator, streams it MSB word
// first to the bit serializer over valid/ready, waits an inter-packet gap and
// then pulses packetsent. Also hosts the retransmission timer.
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   packet, pkt_valid    - packet from generator, held until pkt_ack
//   pkt_ack              - one-cycle pulse, packet captured
//   word_out, word_valid - current word to serializer
//   word_ready           - serializer accepts word_out this cycle
//   packetsent           - one-cycle pulse after the gap following the last word
//   ack_progress         - incoming ACK number advanced
//   timer_enable         - unacknowledged data outstanding
//   timeout              - one-cycle pulse, retransmit timer expired
//   busy                 - scheduler not in IDLE
module laser_tx_scheduler
    import lasernet_pkg::*;
#(
    parameter int unsigned WORDS          = DEF_WORDS,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned TIMER_W        = DEF_TIMER_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [WORD_W*WORDS-1:0] packet,
    input  logic                    pkt_valid,
    output logic                    pkt_ack,
    output logic [WORD_W-1:0]       word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    packetsent,
    input  logic                    ack_progress,
    input  logic                    timer_enable,
    output logic                    timeout,
    output logic                    busy
);

    localparam int unsigned PKT_W   = WORD_W * WORDS;
    localparam int unsigned IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // Top bit of the word that follows the head of the capture buffer
    localparam int unsigned NEXT_HI = (WORDS > 1) ? (PKT_W - WORD_W - 1) : (WORD_W - 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    tx_state_e          state_q;
    tx_state_e          state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_d;
    logic [WORD_W-1:0]  word_d;
    logic               word_valid_d;
    logic               pkt_ack_d;
    logic               packetsent_d;
    logic               busy_d;
    logic               capture;
    logic               shift;
    logic [PKT_W-1:0]   buf_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        word_d       = word_out;
        word_valid_d = word_valid;
        pkt_ack_d    = 1'b0;
        packetsent_d = 1'b0;
        capture      = 1'b0;
        shift        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pkt_valid) begin
                    capture      = 1'b1;
                    pkt_ack_d    = 1'b1;
                    word_valid_d = 1'b1;
                    word_d       = packet[PKT_W-1 -: WORD_W];
                    idx_d        = '0;
                    state_d      = SEND;
                end
            end

            SEND: begin
                if (word_ready) begin
                    if (idx_q == LAST_IDX) begin
                        word_valid_d = 1'b0;
                        word_d       = '0;
                        idx_d        = '0;
                        // A one-cycle gap completes on the handshake edge itself
                        if (GAP_CYCLES == 1) begin
                            gap_d        = '0;
                            packetsent_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            gap_d   = GAP_LOAD;
                            state_d = GAP;
                        end
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        word_d = buf_q[NEXT_HI -: WORD_W];
                        shift  = 1'b1;
                    end
                end
            end

            GAP: begin
                gap_d = gap_q - GAP_W'(1);
                // Leaving on the edge into count 0 makes packetsent and IDLE coincide
                if (gap_q == GAP_W'(1)) begin
                    packetsent_d = 1'b1;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d      = IDLE;
                word_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            gap_q      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            pkt_ack    <= 1'b0;
            packetsent <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            word_out   <= word_d;
            word_valid <= word_valid_d;
            pkt_ack    <= pkt_ack_d;
            packetsent <= packetsent_d;
            busy       <= busy_d;
        end
    end

    // Capture buffer: head word is the one on word_out, shifted up per handshake
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q <= packet;
        end else if (shift) begin
            buf_q <= buf_q << WORD_W;
        end
    end

    retx_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_W        (TIMER_W)
    ) u_retx_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (timer_enable),
        .clear   (ack_progress | packetsent),
        .timeout (timeout)
    );

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// Scoreboard bench for laser_tx_scheduler: the driver queues expected words,
// a negedge monitor derives expected event cycles from the transfer rules and
// compares everything the DUT presents.
module tb_laser_tx_scheduler;

    localparam int unsigned WORDS = 9;
    localparam int unsigned GAP_N = 650;
    localparam int unsigned TO_N  = 100;
    localparam int unsigned TW    = 27;
    localparam int unsigned PW    = 32 * WORDS;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [PW-1:0] packet;
    logic          pkt_valid;
    logic          pkt_ack;
    logic [31:0]   word_out;
    logic          word_valid;
    logic          word_ready;
    logic          packetsent;
    logic          ack_progress;
    logic          timer_enable;
    logic          timeout;
    logic          busy;

    always #5 clk = ~clk;

    laser_tx_scheduler #(
        .WORDS          (WORDS),
        .GAP_CYCLES     (GAP_N),
        .TIMEOUT_CYCLES (TO_N),
        .TIMER_W        (TW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .packet       (packet),
        .pkt_valid    (pkt_valid),
        .pkt_ack      (pkt_ack),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .packetsent   (packetsent),
        .ack_progress (ack_progress),
        .timer_enable (timer_enable),
        .timeout      (timeout),
        .busy         (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] wq[$];
    int          ackq[$];
    int          sentq[$];
    int          toq[$];
    bit          m_busy = 1'b0;
    int          hs_in_pkt = 0;
    int          since = 0;
    int          n_to = 0;
    int          n_sent = 0;
    bit          ready_rand = 1'b0;
    bit          timer_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not matched (cycle %0d)", name, cyc);
    endtask

    // Monitor and reference model
    always @(negedge clk) begin
        if (!reset_n) begin
            wq.delete();
            ackq.delete();
            sentq.delete();
            toq.delete();
            m_busy    = 1'b0;
            hs_in_pkt = 0;
            since     = 0;
        end else begin
            if (ackq.size() > 0 && ackq[0] < cyc) begin
                flag("ack_missing");
                void'(ackq.pop_front());
            end
            if (pkt_ack) begin
                if (ackq.size() == 0) flag("ack_unexpected");
                else check("ack_cycle", cyc, ackq.pop_front());
                check("busy_at_ack", busy, 1);
                hs_in_pkt = 0;
            end

            if (word_valid) begin
                if (wq.size() == 0) flag("word_unexpected");
                else begin
                    check("word_out", word_out, wq[0]);
                    if (word_ready) begin
                        void'(wq.pop_front());
                        hs_in_pkt++;
                        if (hs_in_pkt == WORDS) sentq.push_back(cyc + GAP_N);
                    end
                end
            end

            if (sentq.size() > 0 && sentq[0] < cyc) begin
                flag("sent_missing");
                void'(sentq.pop_front());
            end
            if (packetsent) begin
                if (sentq.size() == 0) flag("sent_unexpected");
                else check("sent_cycle", cyc, sentq.pop_front());
                check("busy_at_sent", busy, 0);
                m_busy = 1'b0;
                n_sent++;
            end

            // An idle scheduler accepts a presented packet on this cycle's edge
            if (pkt_valid && !m_busy) begin
                ackq.push_back(cyc + 1);
                m_busy = 1'b1;
            end

            if (toq.size() > 0 && toq[0] < cyc) begin
                flag("timeout_missing");
                void'(toq.pop_front());
            end
            if (timeout) begin
                if (toq.size() == 0) flag("timeout_unexpected");
                else check("timeout_cycle", cyc, toq.pop_front());
                n_to++;
            end

            // Timer: TO_N uninterrupted enabled cycles since the last clear fire a pulse
            if (!timer_enable || ack_progress || packetsent) since = 0;
            else begin
                since++;
                if (since == TO_N) begin
                    toq.push_back(cyc + 1);
                    since = 0;
                end
            end
        end
    end

    // Random background stimulus
    always @(posedge clk) begin
        #2;
        if (ready_rand) word_ready = ($urandom_range(0, 3) != 0);
        if (timer_rand) begin
            ack_progress = ($urandom_range(0, 120) == 0);
            if ($urandom_range(0, 199) == 0) timer_enable = ~timer_enable;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_pkt(input logic [PW-1:0] p);
        logic [PW-1:0] tmp;
        tmp = p;
        for (int k = 0; k < WORDS; k++) begin
            wq.push_back(tmp[PW-1 -: 32]);
            tmp = tmp << 32;
        end
        packet    = p;
        pkt_valid = 1'b1;
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        logic [PW-1:0] tmp;
        tmp = '0;
        for (int k = 0; k < WORDS; k++) tmp = {tmp[PW-33:0], 32'($urandom())};
        return tmp;
    endfunction

    task automatic wait_ack(output int c);
        c = -1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (pkt_ack) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) flag("ack_wait_expired");
    endtask

    task automatic wait_sent(output int c);
        c = -1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (packetsent) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) flag("sent_wait_expired");
    endtask

    task automatic wait_hs(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (hs_in_pkt == n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("handshake_wait_expired");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pkt_ack"}, pkt_ack, 0);
        check({tag, "_word_valid"}, word_valid, 0);
        check({tag, "_word_out"}, word_out, 0);
        check({tag, "_packetsent"}, packetsent, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v, a, s, a1, a2, s1, s2, t0, n0, c;
        logic [PW-1:0] p;

        reset_n      = 1'b0;
        pkt_valid    = 1'b0;
        packet       = '0;
        word_ready   = 1'b1;
        ack_progress = 1'b0;
        timer_enable = 1'b0;

        repeat (3) step();
        check_all_zero("reset");
        reset_n = 1'b1;

        // Basic transfer: words 0..8, pkt_valid at cycle 10
        while (cyc < 10) step();
        p = '0;
        for (int k = 0; k < WORDS; k++) p = {p[PW-33:0], 32'(k)};
        v = cyc;
        start_pkt(p);
        wait_ack(a);
        pkt_valid = 1'b0;
        check("basic_ack_cycle", a, v + 1);
        wait_sent(s);
        check("basic_sent_cycle", s, v + WORDS + GAP_N);

        // Backpressure: ready low 5 cycles while word 3 is presented
        step();
        start_pkt(rand_pkt());
        wait_ack(a);
        pkt_valid = 1'b0;
        wait_hs(3);
        word_ready = 1'b0;
        repeat (5) step();
        word_ready = 1'b1;
        wait_sent(s);
        check("bp_sent_delay", s - a, WORDS - 1 + GAP_N + 5);

        // Back-to-back with pkt_valid held; packet input changes during SEND
        step();
        start_pkt(rand_pkt());
        wait_ack(a1);
        start_pkt(rand_pkt());
        wait_sent(s1);
        wait_ack(a2);
        check("b2b_ack_after_sent", a2, s1 + 1);
        pkt_valid = 1'b0;
        packet    = rand_pkt();
        wait_sent(s2);
        check("b2b_second_sent", s2 - a2, WORDS - 1 + GAP_N);

        // Randomized traffic, ready and timer activity
        timer_enable = 1'b1;
        ready_rand   = 1'b1;
        timer_rand   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (!pkt_valid) start_pkt(rand_pkt());
            wait_ack(a);
            if (k < 5 && $urandom_range(0, 1) == 1) begin
                start_pkt(rand_pkt());
            end else begin
                pkt_valid = 1'b0;
                packet    = rand_pkt();
                wait_sent(s);
                repeat ($urandom_range(0, 20)) step();
            end
        end
        ready_rand = 1'b0;
        timer_rand = 1'b0;
        step();
        word_ready   = 1'b1;
        ack_progress = 1'b0;

        // Timeout period from a clear
        timer_enable = 1'b1;
        ack_progress = 1'b1;
        step();
        ack_progress = 1'b0;
        t0 = n_to;
        repeat (350) step();
        check("timeout_pulses_in_350", n_to - t0, 3);

        // ack_progress coincident with the expiry cycle
        c = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (since == TO_N - 1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) flag("expiry_wait_expired");
        ack_progress = 1'b1;
        step();
        ack_progress = 1'b0;
        t0 = n_to;
        repeat (99) step();
        check("timeout_suppressed", n_to - t0, 0);
        repeat (2) step();
        check("timeout_after_suppress", n_to - t0, 1);
        timer_enable = 1'b0;

        // Reset during word 4
        timer_enable = 1'b1;
        step();
        start_pkt(rand_pkt());
        wait_ack(a);
        pkt_valid = 1'b0;
        wait_hs(4);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) step();
        check_all_zero("held_reset");
        reset_n = 1'b1;
        n0 = n_sent;
        repeat (700) step();
        check("no_sent_after_reset", n_sent - n0, 0);

        p = '0;
        for (int k = 0; k < WORDS; k++) p = {p[PW-33:0], 32'(32'h100 + k)};
        start_pkt(p);
        wait_ack(a);
        pkt_valid = 1'b0;
        wait_sent(s);
        check("post_reset_sent", s - a, WORDS - 1 + GAP_N);
        timer_enable = 1'b0;

        repeat (5) step();
        check("words_left", wq.size(), 0);
        check("acks_left", ackq.size(), 0);
        check("sents_left", sentq.size(), 0);
        check("timeouts_left", toq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
